// File: rtl/fsm_share_sched_pkg.sv
// Shared definitions for the fsm time-share scheduler.
//   state_t : scheduler state encoding (IDLE/CLR/RUN/DONE)
//   DEF_N   : default number of requesters
//   DEF_LW  : default width of one burst-length field
package fsm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_N  = 4;
  localparam int DEF_LW = 4;

endpackage

// File: rtl/fsm_share_sched_if.sv
// Requester-side bundle of the fsm time-share scheduler.
//   req/a_in/b_in/len : per-requester request, symbols and burst length (master -> slave)
//   gnt/done/busy     : grant, completion pulse and occupancy (slave -> master)
//   m_out/n_out       : shared fsm outputs forwarded to the owner, qualified by out_vld
interface fsm_share_sched_if #(
  parameter int N  = 4,
  parameter int LW = 4
);
  logic [N-1:0]    req;
  logic [N-1:0]    a_in;
  logic [N-1:0]    b_in;
  logic [N*LW-1:0] len;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            busy;
  logic            m_out;
  logic            n_out;
  logic            out_vld;

  modport master (
    output req, a_in, b_in, len,
    input  gnt, done, busy, m_out, n_out, out_vld
  );

  modport slave (
    input  req, a_in, b_in, len,
    output gnt, done, busy, m_out, n_out, out_vld
  );
endinterface

// File: rtl/fsm_share_sched_rr_pick.sv
// Combinational rotating-priority picker.
//   req    : request vector
//   last   : index of the previous winner; scan starts at last+1 and wraps
//   onehot : winner as one-hot (0 when no request)
//   idx    : winner index
//   any    : at least one request present
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Walk the scan order backwards so the closest requester after 'last'
  // is the final (winning) assignment.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = IW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_share_sched.sv
// Time-multiplexes one shared a/b -> m/n fsm between N requesters.
// Round-robin grants, each a burst of len cycles (0 counts as 1); the shared
// fsm is held in reset for one cycle before each burst so no state leaks
// between owners.
//   clk, rst_b     : clock and synchronous active-high reset
//   bus            : requester side (req/a_in/b_in/len in, gnt/done/busy/m_out/n_out/out_vld out)
//   fsm_rst_b      : active-low reset to the shared fsm
//   fsm_a, fsm_b   : symbols to the shared fsm (owner's a_in/b_in during RUN)
//   fsm_m, fsm_n   : shared fsm outputs
module fsm_share_sched
  import fsm_sched_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int LW = DEF_LW
) (
  input  logic                clk,
  input  logic                rst_b,
  fsm_share_sched_if.slave    bus,
  output logic                fsm_rst_b,
  output logic                fsm_a,
  output logic                fsm_b,
  input  logic                fsm_m,
  input  logic                fsm_n
);

  localparam int IW = $clog2(N);

  state_t         state_q, state_d;
  logic [LW-1:0]  cnt_q;
  logic [IW-1:0]  owner_q, last_q;
  logic [N-1:0]   gnt_q, done_q;

  logic [N-1:0]   pick_oh;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic [LW-1:0]  pick_len;
  logic           run;

  rr_pick #(.N(N)) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign pick_len = bus.len[int'(pick_idx)*LW +: LW];

  // state register
  always_ff @(posedge clk) begin
    if (rst_b) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // burst bookkeeping; last resets to N-1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst_b) begin
      cnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IW'(N-1);
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: if (pick_any) begin
          owner_q <= pick_idx;
          gnt_q   <= pick_oh;
          cnt_q   <= (pick_len == '0) ? LW'(1) : pick_len;
        end
        ST_RUN: begin
          cnt_q <= cnt_q - LW'(1);
          // final RUN cycle: grant drops and done fires as we enter DONE
          if (cnt_q == LW'(1)) begin
            gnt_q  <= '0;
            done_q <= gnt_q;
            last_q <= owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_CLR;
      ST_CLR:  state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LW'(1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs; reset masks the combinational ones immediately, before the
  // registers have been cleared by the edge
  always_comb begin
    run         = (state_q == ST_RUN) && !rst_b;
    fsm_rst_b   = !rst_b && (state_q != ST_CLR);
    fsm_a       = run & bus.a_in[owner_q];
    fsm_b       = run & bus.b_in[owner_q];
    bus.m_out   = run & fsm_m;
    bus.n_out   = run & fsm_n;
    bus.out_vld = run;
    bus.busy    = !rst_b && (state_q != ST_IDLE);
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_fsm_share_sched.sv
module tb_fsm_share_sched;

  localparam int N  = 4;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_b;
  logic fsm_rst_b, fsm_a, fsm_b, fsm_m, fsm_n;

  fsm_share_sched_if #(.N(N), .LW(LW)) bus ();

  fsm_share_sched #(.N(N), .LW(LW)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .fsm_rst_b (fsm_rst_b),
    .fsm_a     (fsm_a),
    .fsm_b     (fsm_b),
    .fsm_m     (fsm_m),
    .fsm_n     (fsm_n)
  );

  always #5 clk = ~clk;

  // stand-in shared fsm: small state machine with a Mealy output
  logic [1:0] fst;
  always @(posedge clk) begin
    if (!fsm_rst_b) fst <= 2'b00;
    else            fst <= {fst[0] ^ fsm_b, fst[1] ^ fsm_a};
  end
  assign fsm_m = fst[0] ^ fsm_a;
  assign fsm_n = fst[1];

  // ---------------- behavioural model ----------------
  // pos = -1 idle, otherwise cycle position inside a burst of blen:
  // 0 = clear cycle, 1..blen = active cycles, blen+1 = completion cycle.
  int pos = -1, blen = 1, mown = 0, mlast = N - 1;
  bit started = 1'b0;

  function automatic int rr(logic [N-1:0] r, int l);
    for (int k = 1; k <= N; k++)
      if (r[(l + k) % N]) return (l + k) % N;
    return 0;
  endfunction

  function automatic int eff_len(int who);
    int v;
    v = int'(bus.len[who*LW +: LW]);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst_b) begin
      pos   <= -1;
      mlast <= N - 1;
    end else if (pos < 0) begin
      if (bus.req != '0) begin
        mown <= rr(bus.req, mlast);
        blen <= eff_len(rr(bus.req, mlast));
        pos  <= 0;
      end
    end else if (pos == blen + 1) begin
      pos   <= -1;
      mlast <= mown;
    end else begin
      pos <= pos + 1;
    end
  end

  // ---------------- checking ----------------
  int npass = 0, ntot = 0, cyc = 0;
  int nvld = 0, ngnt = 0, nbusy = 0;
  int done_log[$];
  int done_cyc[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cycle_check();
    logic [N-1:0] eg, ed;
    logic run;
    run = !rst_b && pos >= 1 && pos <= blen;
    eg = '0;
    ed = '0;
    if (pos >= 0 && pos <= blen) eg[mown] = 1'b1;
    if (pos == blen + 1)         ed[mown] = 1'b1;
    chk("gnt",       32'(bus.gnt),     32'(eg));
    chk("done",      32'(bus.done),    32'(ed));
    chk("busy",      32'(bus.busy),    32'(!rst_b && pos >= 0));
    chk("out_vld",   32'(bus.out_vld), 32'(run));
    chk("fsm_rst_b", 32'(fsm_rst_b),   32'(!rst_b && pos != 0));
    chk("fsm_a",     32'(fsm_a),       32'(run & bus.a_in[mown]));
    chk("fsm_b",     32'(fsm_b),       32'(run & bus.b_in[mown]));
    chk("m_out",     32'(bus.m_out),   32'(run & fsm_m));
    chk("n_out",     32'(bus.n_out),   32'(run & fsm_n));
    chk("gnt_onehot",  32'($onehot0(bus.gnt)),  32'(1));
    chk("done_onehot", 32'($onehot0(bus.done)), 32'(1));
    if (bus.out_vld) nvld++;
    if (|bus.gnt)    ngnt++;
    if (bus.busy)    nbusy++;
    if (|bus.done) begin
      done_log.push_back($clog2(bus.done));
      done_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  // one cycle: check at negedge+1, then refresh the a/b symbols
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (started) cycle_check();
      bus.a_in = N'($urandom);
      bus.b_in = N'($urandom);
    end
  endtask

  task automatic wait_idle(string nm, int max);
    for (int i = 0; i < max; i++) begin
      step(1);
      if (!bus.busy) return;
    end
    chk({nm, "_idle_timeout"}, 32'(1), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    int b0, b1, b2, b3, d0;
    rst_b    = 1'b1;
    bus.req  = 4'b1111;
    bus.len  = 16'h1111;
    bus.a_in = '0;
    bus.b_in = '0;

    // 1: reset held with all requests up, first grant goes to requester 0
    step(3);
    chk("t1_rst_gnt",  32'(bus.gnt),   32'(0));
    chk("t1_rst_busy", 32'(bus.busy),  32'(0));
    chk("t1_rst_frb",  32'(fsm_rst_b), 32'(0));
    rst_b = 1'b0;
    step(1);
    chk("t1_first_gnt", 32'(bus.gnt), 32'(4'b0001));
    bus.req = '0;
    wait_idle("t1", 30);

    // 2: single request, len 3
    b0 = nvld; b1 = ngnt; b2 = nbusy; d0 = done_log.size();
    bus.req = 4'b0100;
    bus.len = 16'h0300;
    step(1);
    bus.req = '0;
    wait_idle("t2", 30);
    chk("t2_vld_cycles",  32'(nvld - b0),  32'(3));
    chk("t2_gnt_cycles",  32'(ngnt - b1),  32'(4));
    chk("t2_busy_cycles", 32'(nbusy - b2), 32'(5));
    chk("t2_done_count",  32'(done_log.size() - d0), 32'(1));
    if (done_log.size() > d0) chk("t2_done_who", 32'(done_log[d0]), 32'(2));

    // 3: all requesting, len 1 each: order 0,1,2,3,0, 4 cycles apart
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    bus.req = 4'b1111;
    bus.len = 16'h1111;
    d0 = done_log.size();
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (done_log.size() - d0 >= 5) break;
    end
    bus.req = '0;
    chk("t3_done_count", 32'(done_log.size() - d0), 32'(5));
    if (done_log.size() - d0 >= 5) begin
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t3_order%0d", i), 32'(done_log[d0+i]), 32'(exp_ord[i]));
        if (i > 0)
          chk($sformatf("t3_spacing%0d", i), 32'(done_cyc[d0+i] - done_cyc[d0+i-1]), 32'(4));
      end
    end
    wait_idle("t3", 30);

    // 4: zero length counts as one
    b0 = nvld; d0 = done_log.size();
    bus.len = 16'h0000;
    bus.req = 4'b0010;
    step(1);
    bus.req = '0;
    wait_idle("t4", 30);
    chk("t4_vld_cycles", 32'(nvld - b0), 32'(1));
    chk("t4_done_count", 32'(done_log.size() - d0), 32'(1));
    if (done_log.size() > d0) chk("t4_done_who", 32'(done_log[d0]), 32'(1));

    // 5: request dropped after the first active cycle, len 5
    b0 = nvld; d0 = done_log.size();
    bus.len = 16'h0005;
    bus.req = 4'b0001;
    step(2);
    bus.req = '0;
    wait_idle("t5", 30);
    chk("t5_vld_cycles", 32'(nvld - b0), 32'(5));
    chk("t5_done_count", 32'(done_log.size() - d0), 32'(1));
    if (done_log.size() > d0) chk("t5_done_who", 32'(done_log[d0]), 32'(0));

    // 6: reset during active cycle 2 of 4 aborts without done
    d0 = done_log.size();
    bus.len = 16'h0400;
    bus.req = 4'b0100;
    step(1);
    bus.req = 4'b1111;
    step(2);
    chk("t6_in_run", 32'(bus.out_vld), 32'(1));
    rst_b = 1'b1;
    step(1);
    chk("t6_rst_gnt",  32'(bus.gnt),   32'(0));
    chk("t6_rst_done", 32'(bus.done),  32'(0));
    chk("t6_rst_busy", 32'(bus.busy),  32'(0));
    chk("t6_rst_frb",  32'(fsm_rst_b), 32'(0));
    chk("t6_no_done",  32'(done_log.size() - d0), 32'(0));
    rst_b = 1'b0;
    step(1);
    chk("t6_restart_gnt", 32'(bus.gnt), 32'(4'b0001));
    bus.req = '0;
    wait_idle("t6", 30);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
